// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed hex display driver.
// Double-buffered load, leading-zero blanking, per-digit dp and blink.
module seg7_scan #(
    parameter int SCAN_DIV     = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  en,
    output logic [6:0]  c,
    output logic        dp,
    output logic        pending,
    output logic        frame
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SCAN_DIV-1:0] presc;
    logic [2:0]          idx;
    logic                tick;
    logic                wrap;

    logic [31:0]         shadow_val;
    logic [7:0]          shadow_dp;
    logic [31:0]         active_val;
    logic [7:0]          active_dp;

    logic [BW-1:0]       bcnt;
    logic                phase;

    logic [3:0]          nib;
    logic                lz_blank;
    logic                bl_blank;
    logic [7:0]          en_d;
    logic [6:0]          c_d;
    logic                dp_d;

    // active-low {g,f,e,d,c,b,a} hex glyphs
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = &presc;
    assign wrap = tick && (idx == 3'd7);

    // Free-running dwell prescaler
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Digit index advances once per dwell; 7 -> 0 closes a frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= 3'd0;
        end else if (tick) begin
            idx <= idx + 3'd1;
        end
    end

    // One-cycle marker for the first cycle of each frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame <= 1'b0;
        end else begin
            frame <= wrap;
        end
    end

    // Shadow/active buffers; swap only at the frame boundary
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (wrap && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES complete frames
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (bcnt == BLINK_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + 1'b1;
            end
        end
    end

    // Glyph and blanking for the digit under the scan index
    always_comb begin
        nib      = active_val[{idx, 2'b00} +: 4];
        lz_blank = blank_lz && (idx != 3'd0) &&
                   ((active_val >> {idx, 2'b00}) == 32'd0);
        bl_blank = blink_mask[idx] && phase;
        en_d     = 8'hFF;
        c_d      = 7'h7F;
        dp_d     = 1'b1;
        if (!(lz_blank || bl_blank)) begin
            en_d = ~(8'b1 << idx);
            c_d  = hex7(nib);
            dp_d = ~active_dp[idx];
        end
    end

    // Registered pin drivers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en <= 8'hFF;
            c  <= 7'h7F;
            dp <= 1'b1;
        end else begin
            en <= en_d;
            c  <= c_d;
            dp <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed vector bench for seg7_scan.
// SCAN_DIV=2 (4-clock dwell, 32-clock frame), BLINK_FRAMES=2.
module tb_seg7_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  en;
    logic [6:0]  c;
    logic        dp;
    logic        pending;
    logic        frame;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  m;
        logic        blz;
        int          d;
        logic [7:0]  en;
        logic [6:0]  c;
        logic        dp;
    } vec_t;

    vec_t tbl[27];

    always #5 clock = ~clock;

    seg7_scan #(.SCAN_DIV(2), .BLINK_FRAMES(2)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .blink_mask(blink_mask),
        .en(en), .c(c), .dp(dp), .pending(pending), .frame(frame)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame !== 1'b1 && n < 100);
        if (frame !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: got 0 want 1");
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] m);
        int n = 0;
        @(negedge clock);
        value = v;
        dp_mask = m;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("pending_set", 32'(pending), 32'd1);
        while (pending === 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("pending_clr", 32'(pending), 32'd0);
    endtask

    task automatic show(input int k, output logic [7:0] e,
                        output logic [6:0] s, output logic p);
        wait_frame();
        repeat (4 * k + 2) @(posedge clock);
        @(negedge clock);
        e = en;
        s = c;
        p = dp;
    endtask

    task automatic chk_dig(input string nm, input int k,
                           input logic [7:0] xe, input logic [6:0] xc,
                           input logic xp);
        logic [7:0] e;
        logic [6:0] s;
        logic       p;
        show(k, e, s, p);
        chk({nm, "_en"}, 32'(e), 32'(xe));
        chk({nm, "_c"}, 32'(s), 32'(xc));
        chk({nm, "_dp"}, 32'(p), 32'(xp));
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_en"}, 32'(en), 32'hFF);
        chk({nm, "_c"}, 32'(c), 32'h7F);
        chk({nm, "_dp"}, 32'(dp), 32'd1);
        chk({nm, "_pend"}, 32'(pending), 32'd0);
        chk({nm, "_frame"}, 32'(frame), 32'd0);
    endtask

    initial begin
        logic [31:0] pv;
        logic [7:0]  pm;

        tbl[0]  = '{32'h12345678, 8'h80, 1'b0, 0, 8'hFE, 7'h00, 1'b1};
        tbl[1]  = '{32'h12345678, 8'h80, 1'b0, 7, 8'h7F, 7'h79, 1'b0};
        tbl[2]  = '{32'h12345678, 8'h80, 1'b0, 3, 8'hF7, 7'h12, 1'b1};
        tbl[3]  = '{32'h00000A05, 8'h00, 1'b1, 7, 8'hFF, 7'h7F, 1'b1};
        tbl[4]  = '{32'h00000A05, 8'h00, 1'b1, 3, 8'hFF, 7'h7F, 1'b1};
        tbl[5]  = '{32'h00000A05, 8'h00, 1'b1, 2, 8'hFB, 7'h08, 1'b1};
        tbl[6]  = '{32'h00000A05, 8'h00, 1'b1, 1, 8'hFD, 7'h40, 1'b1};
        tbl[7]  = '{32'h00000A05, 8'h00, 1'b1, 0, 8'hFE, 7'h12, 1'b1};
        tbl[8]  = '{32'h00000000, 8'h00, 1'b1, 0, 8'hFE, 7'h40, 1'b1};
        tbl[9]  = '{32'h00000000, 8'h00, 1'b1, 4, 8'hFF, 7'h7F, 1'b1};
        tbl[10] = '{32'h89ABCDEF, 8'h01, 1'b0, 0, 8'hFE, 7'h0E, 1'b0};
        tbl[11] = '{32'h89ABCDEF, 8'h01, 1'b0, 1, 8'hFD, 7'h06, 1'b1};
        tbl[12] = '{32'h89ABCDEF, 8'h01, 1'b0, 2, 8'hFB, 7'h21, 1'b1};
        tbl[13] = '{32'h89ABCDEF, 8'h01, 1'b0, 3, 8'hF7, 7'h46, 1'b1};
        tbl[14] = '{32'h89ABCDEF, 8'h01, 1'b0, 4, 8'hEF, 7'h03, 1'b1};
        tbl[15] = '{32'h89ABCDEF, 8'h01, 1'b0, 5, 8'hDF, 7'h08, 1'b1};
        tbl[16] = '{32'h89ABCDEF, 8'h01, 1'b0, 6, 8'hBF, 7'h10, 1'b1};
        tbl[17] = '{32'h89ABCDEF, 8'h01, 1'b0, 7, 8'h7F, 7'h00, 1'b1};
        tbl[18] = '{32'h01234567, 8'h00, 1'b1, 7, 8'hFF, 7'h7F, 1'b1};
        tbl[19] = '{32'h01234567, 8'h00, 1'b1, 6, 8'hBF, 7'h79, 1'b1};
        tbl[20] = '{32'h01234567, 8'h00, 1'b1, 5, 8'hDF, 7'h24, 1'b1};
        tbl[21] = '{32'h01234567, 8'h00, 1'b1, 1, 8'hFD, 7'h02, 1'b1};
        tbl[22] = '{32'h01234567, 8'h00, 1'b0, 7, 8'h7F, 7'h40, 1'b1};
        tbl[23] = '{32'h00010000, 8'h28, 1'b1, 3, 8'hF7, 7'h40, 1'b0};
        tbl[24] = '{32'h00010000, 8'h28, 1'b1, 5, 8'hFF, 7'h7F, 1'b1};
        tbl[25] = '{32'h00010000, 8'h28, 1'b1, 4, 8'hEF, 7'h79, 1'b1};
        tbl[26] = '{32'h00010000, 8'h28, 1'b1, 0, 8'hFE, 7'h40, 1'b1};

        // power-on reset
        #2 reset = 1'b0;
        #1 chk_rst("por");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_en", 32'(en), 32'hFE);
        chk("rel_c", 32'(c), 32'h40);

        // reset mid-scan with a load still pending
        repeat (9) @(negedge clock);
        value = 32'h12345678;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("mid_pend", 32'(pending), 32'd1);
        #2 reset = 1'b0;
        #1 chk_rst("mid");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rel_en", 32'(en), 32'hFE);
        chk("mid_rel_c", 32'(c), 32'h40);
        chk_dig("discard_d0", 0, 8'hFE, 7'h40, 1'b1);
        chk_dig("discard_d7", 7, 8'h7F, 7'h40, 1'b1);

        // table of static display vectors
        pv = '0;
        pm = '0;
        for (int i = 0; i < 27; i++) begin
            blank_lz = tbl[i].blz;
            if (i == 0 || tbl[i].v != pv || tbl[i].m != pm) begin
                do_load(tbl[i].v, tbl[i].m);
                pv = tbl[i].v;
                pm = tbl[i].m;
            end
            chk_dig($sformatf("vec%0d", i), tbl[i].d,
                    tbl[i].en, tbl[i].c, tbl[i].dp);
        end

        // loads landing exactly on consecutive frame edges
        blank_lz = 1'b0;
        do_load(32'h00000001, 8'h00);
        wait_frame();
        repeat (31) @(posedge clock);
        @(negedge clock);
        value = 32'h0000000A;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("edgeA_frame", 32'(frame), 32'd1);
        chk("edgeA_pend", 32'(pending), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("edgeA_old_c", 32'(c), 32'h79);
        repeat (29) @(posedge clock);
        @(negedge clock);
        value = 32'h0000000B;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("edgeB_frame", 32'(frame), 32'd1);
        chk("edgeB_pend", 32'(pending), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("edgeB_A_c", 32'(c), 32'h08);
        chk("edgeB_A_pend", 32'(pending), 32'd1);
        chk_dig("edgeC_B", 0, 8'hFE, 7'h03, 1'b1);
        chk("edgeC_pend", 32'(pending), 32'd0);

        // blink from a clean reset: lit, dark, dark, lit, lit, dark
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        blink_mask = 8'h01;
        dp_mask = 8'h01;
        value = 32'h00000003;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk_dig("blk_f1", 0, 8'hFE, 7'h30, 1'b0);
        chk_dig("blk_f2", 0, 8'hFF, 7'h7F, 1'b1);
        chk_dig("blk_f3", 0, 8'hFF, 7'h7F, 1'b1);
        chk_dig("blk_f4", 0, 8'hFE, 7'h30, 1'b0);
        chk_dig("blk_f5", 0, 8'hFE, 7'h30, 1'b0);
        chk_dig("blk_f6", 0, 8'hFF, 7'h7F, 1'b1);
        chk_dig("blk_f7_d1", 1, 8'hFD, 7'h40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
